// File: rtl/bp_be_ptw_arbiter_pkg.sv
// bp_be_pkg: shared types for the backend page-table-walk arbiter.
//   bp_params_e            - processor configuration selector
//   bp_vtag_width/...      - width helpers derived from a configuration
//   bp_be_ptw_arb_state_e  - arbiter FSM states
//   bp_be_ptw_owner_e      - which TLB owns the walk in flight
package bp_be_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0,  // Sv39, 40-bit physical address
        e_bp_small_cfg   = 1'b1   // Sv32, 34-bit physical address
    } bp_params_e;

    localparam int unsigned page_offset_width_gp = 12;
    localparam int unsigned pte_flag_width_gp    = 8;

    function automatic int unsigned bp_vtag_width(bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 20 : 27;
    endfunction

    function automatic int unsigned bp_paddr_width(bp_params_e cfg);
        return (cfg == e_bp_small_cfg) ? 34 : 40;
    endfunction

    // Leaf entry layout: {flags, ptag}; ptag occupies the low bits.
    function automatic int unsigned bp_pte_entry_leaf_width(int unsigned paddr_width);
        return (paddr_width - page_offset_width_gp) + pte_flag_width_gp;
    endfunction

    typedef enum logic [1:0] {
        e_ptw_arb_idle = 2'd0,
        e_ptw_arb_send = 2'd1,
        e_ptw_arb_wait = 2'd2
    } bp_be_ptw_arb_state_e;

    typedef enum logic {
        e_ptw_owner_itlb = 1'b0,
        e_ptw_owner_dtlb = 1'b1
    } bp_be_ptw_owner_e;

endpackage

// File: rtl/bp_be_ptw_arbiter_if.sv
// Handshake bundle between the ITLB/DTLB miss paths, the page-table walker
// and the arbiter.
//   master - arbiter side (accepts misses, issues walks, writes fills)
//   slave  - environment side (TLBs and walker)
interface bp_be_ptw_arbiter_if
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
);
    localparam int unsigned vtag_width_p   = bp_vtag_width(bp_params_p);
    localparam int unsigned paddr_width_p  = bp_paddr_width(bp_params_p);
    localparam int unsigned entry_width_lp = bp_pte_entry_leaf_width(paddr_width_p);

    logic                      itlb_miss_v_i;
    logic [vtag_width_p-1:0]   itlb_miss_vtag_i;
    logic                      itlb_miss_ready_o;

    logic                      dtlb_miss_v_i;
    logic [vtag_width_p-1:0]   dtlb_miss_vtag_i;
    logic                      dtlb_miss_ready_o;

    logic                      ptw_v_o;
    logic [vtag_width_p-1:0]   ptw_vtag_o;
    logic                      ptw_ready_i;

    logic                      ptw_resp_v_i;
    logic [entry_width_lp-1:0] ptw_resp_entry_i;
    logic                      ptw_resp_fault_i;

    logic                      itlb_fill_v_o;
    logic [vtag_width_p-1:0]   itlb_fill_vtag_o;
    logic [entry_width_lp-1:0] itlb_fill_entry_o;
    logic                      itlb_fault_o;

    logic                      dtlb_fill_v_o;
    logic [vtag_width_p-1:0]   dtlb_fill_vtag_o;
    logic [entry_width_lp-1:0] dtlb_fill_entry_o;
    logic                      dtlb_fault_o;

    modport master (
        input  itlb_miss_v_i, itlb_miss_vtag_i, output itlb_miss_ready_o,
        input  dtlb_miss_v_i, dtlb_miss_vtag_i, output dtlb_miss_ready_o,
        output ptw_v_o, ptw_vtag_o, input ptw_ready_i,
        input  ptw_resp_v_i, ptw_resp_entry_i, ptw_resp_fault_i,
        output itlb_fill_v_o, itlb_fill_vtag_o, itlb_fill_entry_o, itlb_fault_o,
        output dtlb_fill_v_o, dtlb_fill_vtag_o, dtlb_fill_entry_o, dtlb_fault_o
    );

    modport slave (
        output itlb_miss_v_i, itlb_miss_vtag_i, input itlb_miss_ready_o,
        output dtlb_miss_v_i, dtlb_miss_vtag_i, input dtlb_miss_ready_o,
        input  ptw_v_o, ptw_vtag_o, output ptw_ready_i,
        output ptw_resp_v_i, ptw_resp_entry_i, ptw_resp_fault_i,
        input  itlb_fill_v_o, itlb_fill_vtag_o, itlb_fill_entry_o, itlb_fault_o,
        input  dtlb_fill_v_o, dtlb_fill_vtag_o, dtlb_fill_entry_o, dtlb_fault_o
    );

endinterface

// File: rtl/bp_be_ptw_arbiter_rr.sv
// bsg_arb_round_robin: round-robin arbiter.
//   clk_i, reset_i - clock, synchronous active-high reset
//   grants_en_i    - allow any grant this cycle
//   reqs_i         - request vector
//   grants_o       - one-hot grant (zero when disabled or no request)
//   v_o            - some grant is asserted
//   yumi_i         - grant consumed; remember the winner as last-granted
// Search starts just past the last winner, so a tied requester that was not
// served last wins. Last-granted resets to index 0.
module bsg_arb_round_robin #(
    parameter int unsigned width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               grants_en_i,
    input  logic [width_p-1:0] reqs_i,
    output logic [width_p-1:0] grants_o,
    output logic               v_o,
    input  logic               yumi_i
);
    localparam int unsigned idx_width_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [idx_width_lp-1:0] last_q, last_d;
    logic [idx_width_lp-1:0] cand;
    int unsigned             idx;

    always_comb begin
        grants_o = '0;
        last_d   = last_q;
        cand     = '0;
        idx      = 0;
        for (int unsigned off = 1; off <= width_p; off++) begin
            idx  = (int'(last_q) + off) % width_p;
            cand = idx[idx_width_lp-1:0];
            if ((grants_o == '0) && reqs_i[cand]) begin
                grants_o[cand] = 1'b1;
                last_d         = cand;
            end
        end
        if (!grants_en_i) begin
            grants_o = '0;
        end
    end

    assign v_o = |grants_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= '0;
        end else if (yumi_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bp_be_ptw_arbiter.sv
// bp_be_ptw_arbiter: shares one page-table walker between ITLB and DTLB misses.
//   clk_i, reset_i      - clock, synchronous active-high reset
//   bus (master)        - miss requests, walker request/response, TLB fills
//   flush_i             - sfence/satp change; abandon the walk in flight
//   busy_o              - a walk is being requested or awaited
//   itlb/dtlb_walk_count_o - saturating counts of consumed walker responses
module bp_be_ptw_arbiter
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bp_be_ptw_arbiter_if.master bus,
    input  logic                flush_i,
    output logic                busy_o,
    output logic [31:0]         itlb_walk_count_o,
    output logic [31:0]         dtlb_walk_count_o
);
    localparam int unsigned vtag_width_p   = bp_vtag_width(bp_params_p);
    localparam int unsigned paddr_width_p  = bp_paddr_width(bp_params_p);
    localparam int unsigned entry_width_lp = bp_pte_entry_leaf_width(paddr_width_p);

    bp_be_ptw_arb_state_e      state_q, state_d;
    logic                      squash_q, squash_d;
    bp_be_ptw_owner_e          owner_q, owner_d;
    logic [vtag_width_p-1:0]   vtag_q, vtag_d;
    logic [31:0]               itlb_walk_count_q, itlb_walk_count_d;
    logic [31:0]               dtlb_walk_count_q, dtlb_walk_count_d;
    logic [entry_width_lp-1:0] resp_entry;
    logic [1:0]                arb_grants;
    logic                      arb_v;
    logic                      deliver;

    // Grants only exist in IDLE outside flush/reset, so they double as readies.
    bsg_arb_round_robin #(.width_p(2)) rr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .grants_en_i((state_q == e_ptw_arb_idle) & ~flush_i & ~reset_i),
        .reqs_i     ({bus.dtlb_miss_v_i, bus.itlb_miss_v_i}),
        .grants_o   (arb_grants),
        .v_o        (arb_v),
        .yumi_i     (arb_v)
    );

    assign bus.itlb_miss_ready_o = arb_grants[0];
    assign bus.dtlb_miss_ready_o = arb_grants[1];
    assign bus.ptw_vtag_o        = vtag_q;
    assign resp_entry            = bus.ptw_resp_entry_i;
    assign bus.itlb_fill_vtag_o  = vtag_q;
    assign bus.dtlb_fill_vtag_o  = vtag_q;
    assign bus.itlb_fill_entry_o = resp_entry;
    assign bus.dtlb_fill_entry_o = resp_entry;
    assign busy_o                = (state_q != e_ptw_arb_idle) & ~reset_i;
    assign itlb_walk_count_o     = itlb_walk_count_q;
    assign dtlb_walk_count_o     = dtlb_walk_count_q;

    always_comb begin
        state_d           = state_q;
        squash_d          = squash_q;
        owner_d           = owner_q;
        vtag_d            = vtag_q;
        itlb_walk_count_d = itlb_walk_count_q;
        dtlb_walk_count_d = dtlb_walk_count_q;
        bus.ptw_v_o       = 1'b0;
        bus.itlb_fill_v_o = 1'b0;
        bus.itlb_fault_o  = 1'b0;
        bus.dtlb_fill_v_o = 1'b0;
        bus.dtlb_fault_o  = 1'b0;
        // A flush arriving with the response also kills that fill.
        deliver           = ~squash_q & ~flush_i & ~reset_i;

        case (state_q)
            e_ptw_arb_idle: begin
                if (arb_v) begin
                    state_d = e_ptw_arb_send;
                    owner_d = arb_grants[1] ? e_ptw_owner_dtlb : e_ptw_owner_itlb;
                    vtag_d  = arb_grants[1] ? bus.dtlb_miss_vtag_i : bus.itlb_miss_vtag_i;
                end
            end
            e_ptw_arb_send: begin
                bus.ptw_v_o = ~reset_i;
                if (flush_i) begin
                    state_d = e_ptw_arb_idle;
                end else if (bus.ptw_ready_i) begin
                    state_d = e_ptw_arb_wait;
                end
            end
            e_ptw_arb_wait: begin
                if (flush_i) begin
                    squash_d = 1'b1;
                end
                if (bus.ptw_resp_v_i) begin
                    state_d  = e_ptw_arb_idle;
                    squash_d = 1'b0;
                    if (owner_q == e_ptw_owner_itlb) begin
                        bus.itlb_fill_v_o = deliver & ~bus.ptw_resp_fault_i;
                        bus.itlb_fault_o  = deliver & bus.ptw_resp_fault_i;
                        if (itlb_walk_count_q != '1) begin
                            itlb_walk_count_d = itlb_walk_count_q + 32'd1;
                        end
                    end else begin
                        bus.dtlb_fill_v_o = deliver & ~bus.ptw_resp_fault_i;
                        bus.dtlb_fault_o  = deliver & bus.ptw_resp_fault_i;
                        if (dtlb_walk_count_q != '1) begin
                            dtlb_walk_count_d = dtlb_walk_count_q + 32'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = e_ptw_arb_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q           <= e_ptw_arb_idle;
            squash_q          <= 1'b0;
            itlb_walk_count_q <= '0;
            dtlb_walk_count_q <= '0;
        end else begin
            state_q           <= state_d;
            squash_q          <= squash_d;
            itlb_walk_count_q <= itlb_walk_count_d;
            dtlb_walk_count_q <= dtlb_walk_count_d;
        end
    end

    // Tag and owner are only meaningful once a request is accepted.
    always_ff @(posedge clk_i) begin
        owner_q <= owner_d;
        vtag_q  <= vtag_d;
    end

endmodule

// File: tb/tb_bp_be_ptw_arbiter.sv
// Bench for bp_be_ptw_arbiter: directed scenarios with literal expectations,
// followed by random traffic, all checked every cycle against a walk-level
// reference model.
module tb_bp_be_ptw_arbiter;
    import bp_be_pkg::*;

    localparam bp_params_e  CFG = e_bp_default_cfg;
    localparam int unsigned VT  = bp_vtag_width(CFG);
    localparam int unsigned EW  = bp_pte_entry_leaf_width(bp_paddr_width(CFG));
    localparam int unsigned PT  = bp_paddr_width(CFG) - page_offset_width_gp;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        busy_o;
    logic [31:0] icnt, dcnt;

    bp_be_ptw_arbiter_if #(.bp_params_p(CFG)) bus ();

    bp_be_ptw_arbiter #(.bp_params_p(CFG)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .bus              (bus),
        .flush_i          (flush_i),
        .busy_o           (busy_o),
        .itlb_walk_count_o(icnt),
        .dtlb_walk_count_o(dcnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one optional walk record plus round-robin memory.
    bit              m_known  = 1'b0;
    bit              m_walk   = 1'b0;   // a walk exists (requested or awaited)
    bit              m_issued = 1'b0;   // walker has accepted it
    bit              m_squash = 1'b0;
    bit              m_last   = 1'b0;   // last winner: 0 ITLB, 1 DTLB
    bit              m_owner  = 1'b0;
    logic [VT-1:0]   m_vtag   = '0;
    longint unsigned m_cnt [2];

    // Last observed outputs, for literal checks in the directed section.
    bit            o_iready, o_dready, o_ptwv, o_busy, o_ifv, o_ifault, o_dfv, o_dfault;
    logic [VT-1:0] o_ptw_vtag, o_dvtag;
    logic [EW-1:0] o_dentry;
    logic [31:0]   o_icnt, o_dcnt;
    logic [PT-1:0] ptag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit w_v, w, e_ir, e_dr, e_pv, e_busy, e_ifv, e_ifa, e_dfv, e_dfa, take, sq;
        @(negedge clk);
        w_v = 0; w = 0; e_ir = 0; e_dr = 0; e_pv = 0; e_busy = 0;
        e_ifv = 0; e_ifa = 0; e_dfv = 0; e_dfa = 0; take = 0; sq = 0;
        if (!reset_i) begin
            e_busy = m_walk;
            e_pv   = m_walk && !m_issued;
            if (!m_walk && !flush_i) begin
                if (bus.itlb_miss_v_i && bus.dtlb_miss_v_i) begin w_v = 1; w = ~m_last; end
                else if (bus.itlb_miss_v_i) begin w_v = 1; w = 0; end
                else if (bus.dtlb_miss_v_i) begin w_v = 1; w = 1; end
            end
            e_ir = w_v && !w;
            e_dr = w_v && w;
            take = m_walk && m_issued && bus.ptw_resp_v_i;
            if (take) begin
                sq = m_squash || flush_i;
                if (!m_owner) begin e_ifv = !bus.ptw_resp_fault_i && !sq; e_ifa = bus.ptw_resp_fault_i && !sq; end
                else          begin e_dfv = !bus.ptw_resp_fault_i && !sq; e_dfa = bus.ptw_resp_fault_i && !sq; end
            end
        end
        chk("itlb_ready", bus.itlb_miss_ready_o, e_ir);
        chk("dtlb_ready", bus.dtlb_miss_ready_o, e_dr);
        chk("ptw_v", bus.ptw_v_o, e_pv);
        chk("busy", busy_o, e_busy);
        chk("itlb_fill_v", bus.itlb_fill_v_o, e_ifv);
        chk("itlb_fault", bus.itlb_fault_o, e_ifa);
        chk("dtlb_fill_v", bus.dtlb_fill_v_o, e_dfv);
        chk("dtlb_fault", bus.dtlb_fault_o, e_dfa);
        if (e_pv) chk("ptw_vtag", bus.ptw_vtag_o, m_vtag);
        if (e_ifv) begin
            chk("itlb_fill_vtag", bus.itlb_fill_vtag_o, m_vtag);
            chk("itlb_fill_entry", bus.itlb_fill_entry_o, bus.ptw_resp_entry_i);
        end
        if (e_dfv) begin
            chk("dtlb_fill_vtag", bus.dtlb_fill_vtag_o, m_vtag);
            chk("dtlb_fill_entry", bus.dtlb_fill_entry_o, bus.ptw_resp_entry_i);
        end
        if (m_known) begin
            chk("itlb_count", icnt, m_cnt[0]);
            chk("dtlb_count", dcnt, m_cnt[1]);
        end
        o_iready = bus.itlb_miss_ready_o; o_dready = bus.dtlb_miss_ready_o;
        o_ptwv = bus.ptw_v_o; o_ptw_vtag = bus.ptw_vtag_o; o_busy = busy_o;
        o_ifv = bus.itlb_fill_v_o; o_ifault = bus.itlb_fault_o;
        o_dfv = bus.dtlb_fill_v_o; o_dfault = bus.dtlb_fault_o;
        o_dvtag = bus.dtlb_fill_vtag_o; o_dentry = bus.dtlb_fill_entry_o;
        o_icnt = icnt; o_dcnt = dcnt;

        // Advance the model to the state after the coming clock edge.
        if (reset_i) begin
            m_walk = 0; m_issued = 0; m_squash = 0; m_last = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_known = 1;
        end else if (!m_walk) begin
            if (w_v) begin
                m_walk = 1; m_issued = 0; m_owner = w; m_last = w;
                m_vtag = w ? bus.dtlb_miss_vtag_i : bus.itlb_miss_vtag_i;
            end
        end else if (!m_issued) begin
            if (flush_i) m_walk = 0;
            else if (bus.ptw_ready_i) m_issued = 1;
        end else begin
            if (flush_i) m_squash = 1;
            if (bus.ptw_resp_v_i) begin
                if (m_cnt[m_owner] != 64'hFFFF_FFFF) m_cnt[m_owner]++;
                m_walk = 0; m_issued = 0; m_squash = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.itlb_miss_v_i = 0; bus.itlb_miss_vtag_i = '0;
        bus.dtlb_miss_v_i = 0; bus.dtlb_miss_vtag_i = '0;
        bus.ptw_ready_i = 0; bus.ptw_resp_v_i = 0;
        bus.ptw_resp_entry_i = '0; bus.ptw_resp_fault_i = 0;
        flush_i = 0;
    endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        reset_i = 1;
        idle_inputs();
        @(posedge clk); #1;
        step(); step();
        reset_i = 0;

        // DTLB wins the first tie; fill carries ptag 0x5A.
        bus.itlb_miss_v_i = 1; bus.itlb_miss_vtag_i = VT'(8'h11);
        bus.dtlb_miss_v_i = 1; bus.dtlb_miss_vtag_i = VT'(8'h22);
        bus.ptw_ready_i = 1;
        step();
        chk("tie_dtlb_ready", o_dready, 1'b1);
        chk("tie_itlb_ready", o_iready, 1'b0);
        bus.dtlb_miss_v_i = 0;
        step();
        chk("tie_ptw_vtag", o_ptw_vtag, VT'(8'h22));
        bus.ptw_ready_i = 0;
        step(); step();
        bus.ptw_resp_v_i = 1;
        ptag = PT'(8'h5A);
        bus.ptw_resp_entry_i = {8'h0F, ptag};
        step();
        chk("tie_dfill_v", o_dfv, 1'b1);
        chk("tie_dfill_vtag", o_dvtag, VT'(8'h22));
        ptag = o_dentry[PT-1:0];
        chk("tie_dfill_ptag", ptag, PT'(8'h5A));
        bus.ptw_resp_v_i = 0;
        step();
        chk("tie_itlb_next", o_iready, 1'b1);
        chk("tie_dcount", o_dcnt, 32'd1);

        // ITLB walk that faults.
        bus.itlb_miss_v_i = 0; bus.ptw_ready_i = 1;
        step();
        bus.ptw_ready_i = 0; bus.ptw_resp_v_i = 1; bus.ptw_resp_fault_i = 1;
        step();
        chk("fault_ifault", o_ifault, 1'b1);
        chk("fault_ifill_v", o_ifv, 1'b0);
        bus.ptw_resp_v_i = 0; bus.ptw_resp_fault_i = 0;
        step();
        chk("fault_icount", o_icnt, 32'd1);

        // Backpressure while a DTLB miss waits, then flush in WAIT.
        bus.itlb_miss_v_i = 1; bus.itlb_miss_vtag_i = VT'(8'h33);
        step();
        bus.itlb_miss_v_i = 0;
        bus.dtlb_miss_v_i = 1; bus.dtlb_miss_vtag_i = VT'(8'h44);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ptw_v", o_ptwv, 1'b1);
            chk("bp_ptw_vtag", o_ptw_vtag, VT'(8'h33));
            chk("bp_readies", {o_iready, o_dready}, 2'b00);
        end
        bus.ptw_ready_i = 1;
        step();
        bus.ptw_ready_i = 0; flush_i = 1;
        step();
        flush_i = 0; bus.ptw_resp_v_i = 1;
        step();
        chk("fw_no_fill", {o_ifv, o_ifault}, 2'b00);
        bus.ptw_resp_v_i = 0;
        step();
        chk("fw_idle_accept", o_dready, 1'b1);
        chk("fw_busy", o_busy, 1'b0);
        chk("fw_icount", o_icnt, 32'd2);

        // Flush in the response cycle.
        bus.dtlb_miss_v_i = 0; bus.ptw_ready_i = 1;
        step();
        bus.ptw_ready_i = 0; bus.ptw_resp_v_i = 1; bus.ptw_resp_fault_i = 1; flush_i = 1;
        step();
        chk("fr_no_fill", {o_dfv, o_dfault}, 2'b00);
        idle_inputs();
        step();
        chk("fr_dcount", o_dcnt, 32'd2);
        chk("fr_busy", o_busy, 1'b0);

        // Flush in SEND.
        bus.itlb_miss_v_i = 1; bus.itlb_miss_vtag_i = VT'(8'h55);
        step();
        bus.itlb_miss_v_i = 0; flush_i = 1;
        step();
        chk("fs_ptw_v_send", o_ptwv, 1'b1);
        flush_i = 0;
        step();
        chk("fs_ptw_v_after", o_ptwv, 1'b0);
        chk("fs_busy", o_busy, 1'b0);

        // Reset mid-walk.
        bus.itlb_miss_v_i = 1; bus.itlb_miss_vtag_i = VT'(8'h66);
        step();
        bus.itlb_miss_v_i = 0; bus.ptw_ready_i = 1;
        step();
        bus.ptw_ready_i = 0; reset_i = 1;
        step();
        chk("rst_busy", o_busy, 1'b0);
        reset_i = 0; bus.ptw_resp_v_i = 1;
        step();
        chk("rst_no_fill", o_ifv, 1'b0);
        chk("rst_counts", {o_icnt, o_dcnt}, 64'd0);
        chk("rst_idle", o_busy, 1'b0);
        idle_inputs();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.itlb_miss_v_i    = 1'($urandom_range(0, 1));
            bus.itlb_miss_vtag_i = VT'($urandom);
            bus.dtlb_miss_v_i    = 1'($urandom_range(0, 1));
            bus.dtlb_miss_vtag_i = VT'($urandom);
            bus.ptw_ready_i      = 1'($urandom_range(0, 1));
            bus.ptw_resp_v_i     = ($urandom_range(0, 9) < 3);
            bus.ptw_resp_entry_i = EW'({$urandom, $urandom});
            bus.ptw_resp_fault_i = ($urandom_range(0, 3) == 0);
            flush_i              = ($urandom_range(0, 19) == 0);
            reset_i              = ($urandom_range(0, 199) == 0);
            step();
        end
        reset_i = 0;
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
